demux1x2_fifo4b: RTL and testbench
==================================

# demux1x2_fifo4b

Downstream consumer of the 2:1 4-bit valid/data multiplexer stage. Captures the muxed `data_in`/`valid_in` word stream into a small FIFO and distributes words in strict round-robin order to two 4-bit outputs, each with its own `ready` input. The FIFO absorbs bursts from the mux, which has no backpressure.

## Interface
Parameters:
- `WIDTH`, 4: data word width.
- `DEPTH`, 4: FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  word from the mux `data_out`.
- `valid_in`  in  1  word qualifier from the mux `valid_out`.
- `ready_0`  in  1  output 0 consumer can accept a word this cycle.
- `ready_1`  in  1  output 1 consumer can accept a word this cycle.
- `data_out0`  out  WIDTH  registered word for output 0.
- `valid_out0`  out  1  one-cycle pulse qualifying `data_out0`.
- `data_out1`  out  WIDTH  registered word for output 1.
- `valid_out1`  out  1  one-cycle pulse qualifying `data_out1`.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `err`  out  1  sticky overflow flag; present only with `DEMUX_ERR_EN`.

## Operation
- State: storage array `DEPTH×WIDTH`, `wr_ptr`/`rd_ptr` of `log2(DEPTH)` bits, `count` of `log2(DEPTH)+1` bits, destination bit `turn`.
- Pointers wrap modulo DEPTH (natural overflow); `count` never exceeds DEPTH and never goes below 0.
- Pop condition: `pop = !empty && (turn ? ready_1 : ready_0)`.
- On pop:
  - head word is registered into `data_out<turn>`;
  - `valid_out<turn>` is set to 1;
  - the other valid is set to 0;
  - `rd_ptr` increments and `turn` toggles.
- Without a pop, both `valid_out*` are 0.
- Strict alternation: if the current `turn` output is not ready, the FIFO stalls. It never skips to the other output.
- Push condition: `push = valid_in && (!full || pop)`. On push, `data_in` is written at `wr_ptr` and `wr_ptr` increments.
- Count update: push only → `count+1`; pop only → `count−1`; both → unchanged.
- Full plus simultaneous pop: the incoming word is accepted.
- Full with no pop: the incoming word is dropped and the FIFO state is unchanged.
- `data_out0`/`data_out1` hold their last value when their valid is 0.
- `full`/`empty` are combinational decodes of registered `count`.
- Reset (any cycle, including mid-burst) sets all of the following to 0 on the next edge, discarding stored words: pointers, `count`, `turn`, `data_out*`, `valid_out*`, `err`.

## Timing
- Reset values: `data_out0=0`, `data_out1=0`, `valid_out0=0`, `valid_out1=0`, `full=0`, `empty=1`, `err=0`.
- Latency: a word sampled at edge E (`valid_in=1`, not dropped) with an empty FIFO and the target ready appears on `data_out<turn>` with valid high after edge E+1. That is 2 cycles from `valid_in` assertion to `valid_out`. There is no bypass path.
- Sustained throughput: 1 word/cycle in and out when the addressed `ready` stays high. Outputs alternate 0,1,0,1 on consecutive cycles.
- `ready_*` is sampled in the same cycle as the pop decision. `valid_out*` follow one edge later.
- `full`/`empty` reflect state after the most recent edge.

## Configuration
- `DEMUX_ERR_EN` defined:
  - `err` port exists.
  - `err` is set to 1 on any edge where `valid_in && full && !pop` (a dropped word).
  - `err` stays 1 until `reset`.
- Not defined:
  - `err` port and its register are absent.
  - Drops are silent.
  - All other behaviour is identical.

## Test plan
- Reset then idle: after `reset=1` for 2 cycles, then low → all outputs 0, `empty=1`, `full=0`, `err=0`.
- Single word: `data_in=4'hA`, `valid_in=1` for one cycle, `ready_0=ready_1=1` → `valid_out0=1`, `data_out0=4'hA` exactly 2 edges later; `valid_out1` stays 0; `empty` returns to 1.
- Alternation stream: 6 consecutive words 1..6 with both ready → `data_out0` receives 1,3,5 and `data_out1` receives 2,4,6 on alternate cycles, with no gaps after the first output.
- Stall and fill: `ready_0=0`, push 5 words 1..5 → `full=1` after the 4th; word 5 is dropped and `err=1` if `DEMUX_ERR_EN`. Then `ready_0=ready_1=1` → outputs 1,2,3,4 only.
- Full with simultaneous push/pop: FIFO full, `ready_0=1`, `valid_in=1`, `data_in=4'h7` → one word popped, 7 accepted, `full` stays 1, `err` unchanged.
- Reset mid-operation: 3 words stored, assert `reset` for one cycle → next cycle `empty=1` and all outputs 0; the next pushed word goes to output 0.

Source files
------------

// File: rtl/demux1x2_fifo4b.sv
// demux1x2_fifo4b: buffers the muxed word stream in a small FIFO and hands
// words out in strict round-robin order (output 0, then 1, then 0, ...).
// Optional feature macro: DEMUX_ERR_EN adds a sticky overflow flag on port err.
module demux1x2_fifo4b #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             ready_0,
  input  logic             ready_1,
  output logic [WIDTH-1:0] data_out0,
  output logic             valid_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out1,
  output logic             full,
`ifdef DEMUX_ERR_EN
  output logic             err,
`endif
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             turn;
  logic             pop_c;
  logic             push_c;

  // Occupancy decodes of the registered count
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pop only toward the output whose turn it is; push may reuse a slot freed this cycle
  always_comb begin
    pop_c  = 1'b0;
    push_c = 1'b0;
    pop_c  = !empty && (turn ? ready_1 : ready_0);
    push_c = valid_in && (!full || pop_c);
  end

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and round-robin destination
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      turn   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (pop_c) begin
        rd_ptr <= AW'(rd_ptr + 1'b1);
        turn   <= !turn;
      end
      case ({push_c, pop_c})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Registered outputs: head word goes to the addressed port, data holds otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out0  <= '0;
      data_out1  <= '0;
      valid_out0 <= 1'b0;
      valid_out1 <= 1'b0;
    end else begin
      valid_out0 <= pop_c && !turn;
      valid_out1 <= pop_c && turn;
      if (pop_c && !turn) data_out0 <= mem[rd_ptr];
      if (pop_c && turn)  data_out1 <= mem[rd_ptr];
    end
  end

`ifdef DEMUX_ERR_EN
  // Sticky flag for a word dropped because the FIFO was full and not draining
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (valid_in && full && !pop_c) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1x2_fifo4b.sv
// Bench for demux1x2_fifo4b: a hand-derived vector table for the directed
// scenarios, then a random stream checked against a queue-based scoreboard.
module tb_demux1x2_fifo4b;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_0;
  logic             ready_1;
  logic [WIDTH-1:0] data_out0;
  logic             valid_out0;
  logic [WIDTH-1:0] data_out1;
  logic             valid_out1;
  logic             full;
  logic             empty;
`ifdef DEMUX_ERR_EN
  logic             err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  demux1x2_fifo4b #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_0    (ready_0),
    .ready_1    (ready_1),
    .data_out0  (data_out0),
    .valid_out0 (valid_out0),
    .data_out1  (data_out1),
    .valid_out1 (valid_out1),
    .full       (full),
`ifdef DEMUX_ERR_EN
    .err        (err),
`endif
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vin;
    logic [3:0] din;
    logic       r0;
    logic       r1;
    logic       ev0;
    logic [3:0] ed0;
    logic       ev1;
    logic [3:0] ed1;
    logic       efull;
    logic       eempty;
    logic       eerr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic vin, input logic [3:0] din,
                              input logic r0, input logic r1,
                              input logic ev0, input logic [3:0] ed0,
                              input logic ev1, input logic [3:0] ed1,
                              input logic efull, input logic eempty, input logic eerr);
    vec_t v;
    v.rst = rst; v.vin = vin; v.din = din; v.r0 = r0; v.r1 = r1;
    v.ev0 = ev0; v.ed0 = ed0; v.ev1 = ev1; v.ed1 = ed1;
    v.efull = efull; v.eempty = eempty; v.eerr = eerr;
    return v;
  endfunction

  // Apply one vector before a rising edge, then compare outputs 1 time unit after it
  task automatic apply(input string name, input int idx, input vec_t v);
    logic [12:0] act;
    logic [12:0] exp_v;
    logic        act_err;
    logic        exp_err;
    @(negedge clk);
    reset    = v.rst;
    valid_in = v.vin;
    data_in  = v.din;
    ready_0  = v.r0;
    ready_1  = v.r1;
    @(posedge clk);
    #1;
`ifdef DEMUX_ERR_EN
    act_err = err;
    exp_err = v.eerr;
`else
    act_err = 1'b0;
    exp_err = 1'b0;
`endif
    act   = {valid_out0, data_out0, valid_out1, data_out1, full, empty, act_err};
    exp_v = {v.ev0, v.ed0, v.ev1, v.ed1, v.efull, v.eempty, exp_err};
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s[%0d]: got v0=%b d0=%h v1=%b d1=%h full=%b empty=%b err=%b, expected v0=%b d0=%h v1=%b d1=%h full=%b empty=%b err=%b",
               name, idx, valid_out0, data_out0, valid_out1, data_out1, full, empty, act_err,
               v.ev0, v.ed0, v.ev1, v.ed1, v.efull, v.eempty, exp_err);
    end
  endtask

  vec_t       tbl[$];
  logic [3:0] sb_q[$];
  logic       turn_m;
  logic       ev0_m, ev1_m, err_m;
  logic [3:0] ed0_m, ed1_m;

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_0 = 1'b0; ready_1 = 1'b0;

    // Columns: rst vin din r0 r1 | v0 d0 v1 d1 full empty err  (outputs after the edge)
    // reset, then idle
    tbl.push_back(mk(1,0,4'h0,1,1, 0,4'h0,0,4'h0, 0,1,0));
    tbl.push_back(mk(1,0,4'h0,1,1, 0,4'h0,0,4'h0, 0,1,0));
    tbl.push_back(mk(0,0,4'h0,1,1, 0,4'h0,0,4'h0, 0,1,0));
    // single word, appears two edges after it is driven
    tbl.push_back(mk(0,1,4'hA,1,1, 0,4'h0,0,4'h0, 0,0,0));
    tbl.push_back(mk(0,0,4'h0,1,1, 1,4'hA,0,4'h0, 0,1,0));
    tbl.push_back(mk(0,0,4'h0,1,1, 0,4'hA,0,4'h0, 0,1,0));
    // reset clears data outputs and turn
    tbl.push_back(mk(1,0,4'h0,1,1, 0,4'h0,0,4'h0, 0,1,0));
    // alternation stream 1..6
    tbl.push_back(mk(0,1,4'h1,1,1, 0,4'h0,0,4'h0, 0,0,0));
    tbl.push_back(mk(0,1,4'h2,1,1, 1,4'h1,0,4'h0, 0,0,0));
    tbl.push_back(mk(0,1,4'h3,1,1, 0,4'h1,1,4'h2, 0,0,0));
    tbl.push_back(mk(0,1,4'h4,1,1, 1,4'h3,0,4'h2, 0,0,0));
    tbl.push_back(mk(0,1,4'h5,1,1, 0,4'h3,1,4'h4, 0,0,0));
    tbl.push_back(mk(0,1,4'h6,1,1, 1,4'h5,0,4'h4, 0,0,0));
    tbl.push_back(mk(0,0,4'h0,1,1, 0,4'h5,1,4'h6, 0,1,0));
    // stall on output 0 and fill; fifth word dropped
    tbl.push_back(mk(0,1,4'h1,0,1, 0,4'h5,0,4'h6, 0,0,0));
    tbl.push_back(mk(0,1,4'h2,0,1, 0,4'h5,0,4'h6, 0,0,0));
    tbl.push_back(mk(0,1,4'h3,0,1, 0,4'h5,0,4'h6, 0,0,0));
    tbl.push_back(mk(0,1,4'h4,0,1, 0,4'h5,0,4'h6, 1,0,0));
    tbl.push_back(mk(0,1,4'h5,0,1, 0,4'h5,0,4'h6, 1,0,1));
    // drain: only 1..4 come out
    tbl.push_back(mk(0,0,4'h0,1,1, 1,4'h1,0,4'h6, 0,0,1));
    tbl.push_back(mk(0,0,4'h0,1,1, 0,4'h1,1,4'h2, 0,0,1));
    tbl.push_back(mk(0,0,4'h0,1,1, 1,4'h3,0,4'h2, 0,0,1));
    tbl.push_back(mk(0,0,4'h0,1,1, 0,4'h3,1,4'h4, 0,1,1));
    tbl.push_back(mk(0,0,4'h0,1,1, 0,4'h3,0,4'h4, 0,1,1));
    // refill, then push and pop together while full
    tbl.push_back(mk(0,1,4'h8,0,0, 0,4'h3,0,4'h4, 0,0,1));
    tbl.push_back(mk(0,1,4'h9,0,0, 0,4'h3,0,4'h4, 0,0,1));
    tbl.push_back(mk(0,1,4'hA,0,0, 0,4'h3,0,4'h4, 0,0,1));
    tbl.push_back(mk(0,1,4'hB,0,0, 0,4'h3,0,4'h4, 1,0,1));
    tbl.push_back(mk(0,1,4'h7,1,0, 1,4'h8,0,4'h4, 1,0,1));
    tbl.push_back(mk(0,0,4'h0,1,1, 0,4'h8,1,4'h9, 0,0,1));
    tbl.push_back(mk(0,0,4'h0,1,1, 1,4'hA,0,4'h9, 0,0,1));
    tbl.push_back(mk(0,0,4'h0,1,1, 0,4'hA,1,4'hB, 0,0,1));
    tbl.push_back(mk(0,0,4'h0,1,1, 1,4'h7,0,4'hB, 0,1,1));
    // three words stored, reset mid-operation, next word goes to output 0
    tbl.push_back(mk(0,1,4'h1,0,0, 0,4'h7,0,4'hB, 0,0,1));
    tbl.push_back(mk(0,1,4'h2,0,0, 0,4'h7,0,4'hB, 0,0,1));
    tbl.push_back(mk(0,1,4'h3,0,0, 0,4'h7,0,4'hB, 0,0,1));
    tbl.push_back(mk(1,0,4'h0,0,0, 0,4'h0,0,4'h0, 0,1,0));
    tbl.push_back(mk(0,1,4'h5,1,1, 0,4'h0,0,4'h0, 0,0,0));
    tbl.push_back(mk(0,0,4'h0,1,1, 1,4'h5,0,4'h0, 0,1,0));
    tbl.push_back(mk(0,0,4'h0,1,1, 0,4'h5,0,4'h0, 0,1,0));

    foreach (tbl[i]) apply("directed", i, tbl[i]);

    // Random stream: the queue holds words accepted and not yet delivered
    sb_q.delete();
    turn_m = 1'b0; ev0_m = 1'b0; ev1_m = 1'b0; ed0_m = '0; ed1_m = '0; err_m = 1'b0;
    for (int c = 0; c < 400; c++) begin
      vec_t v;
      logic pop_m, push_m, drop_m;
      logic [3:0] w;
      v.rst = (c == 0) || ($urandom_range(0, 63) == 0);
      v.vin = ($urandom_range(0, 3) != 0);
      v.din = 4'($urandom_range(0, 15));
      v.r0  = ($urandom_range(0, 3) != 0);
      v.r1  = ($urandom_range(0, 3) != 0);
      if (v.rst) begin
        sb_q.delete();
        turn_m = 1'b0; ev0_m = 1'b0; ev1_m = 1'b0; ed0_m = '0; ed1_m = '0; err_m = 1'b0;
      end else begin
        pop_m  = (sb_q.size() != 0) && (turn_m ? v.r1 : v.r0);
        push_m = v.vin && ((sb_q.size() < DEPTH) || pop_m);
        drop_m = v.vin && (sb_q.size() == DEPTH) && !pop_m;
        ev0_m  = pop_m && !turn_m;
        ev1_m  = pop_m && turn_m;
        if (pop_m) begin
          w = sb_q.pop_front();
          if (turn_m) ed1_m = w;
          else        ed0_m = w;
          turn_m = !turn_m;
        end
        if (push_m) sb_q.push_back(v.din);
        if (drop_m) err_m = 1'b1;
      end
      v.ev0 = ev0_m; v.ed0 = ed0_m; v.ev1 = ev1_m; v.ed1 = ed1_m;
      v.efull  = (sb_q.size() == DEPTH);
      v.eempty = (sb_q.size() == 0);
      v.eerr   = err_m;
      apply("random", c, v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
